// File: rtl/scan_ctrl_unit.sv
// ---------------------------------------------------------------------------
// scan_ctrl_unit
// Scan-chain controller for the HW/SW co-design test path. A software pattern
// is loaded into per-chain shadow registers, shifted out MSB first on all
// chains in lockstep, and the returning scan stream is captured into a
// parallel register for host readback. Supports abort and a rotate mode in
// which each chain recirculates its own MSB into its LSB.
//
// Ports:
//   CLK, RST_N            clock, async active-low reset
//   start                 request one scan operation (sampled in IDLE only)
//   rotate                0 = capture scan_in, 1 = recirculate (latched at start)
//   abort                 cancel an operation in SHIFT
//   data_in               pattern, chain c at [c*DATA_W +: DATA_W]
//   scan_in               serial return per chain
//   scan_out              serial drive per chain (registered)
//   scan_enable           high for exactly the DATA_W-cycle shift window
//   ctrl_feedback         busy (SHIFT or DONE)
//   scan_shift_feedback   strobe on every shift edge
//   capture_data          result of the last completed operation
//   done                  one-cycle completion pulse
// ---------------------------------------------------------------------------

// Per-chain datapath: shadow shift register, registered serial output and
// capture register.
module scan_ctrl_lane #(
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load,
    input  logic              shift,
    input  logic              last,
    input  logic              rot_mode,
    input  logic [DATA_W-1:0] data,
    input  logic              scan_in,
    output logic              scan_out,
    output logic [DATA_W-1:0] capture
);
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] shadow_nxt;
    logic              fill;

    always_comb begin
        fill       = rot_mode ? shadow[DATA_W-1] : scan_in;
        shadow_nxt = {shadow[DATA_W-2:0], fill};
    end

    // scan_out is its own flop holding the MSB the shadow will have next
    // cycle, gated to zero whenever the next cycle is not a shift cycle.
    // This keeps the chain drive glitch-free and straight off a register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow   <= '0;
            scan_out <= 1'b0;
            capture  <= '0;
        end else if (load) begin
            shadow   <= data;
            scan_out <= data[DATA_W-1];
        end else if (shift) begin
            shadow   <= shadow_nxt;
            scan_out <= last ? 1'b0 : shadow_nxt[DATA_W-1];
            if (last)
                capture <= shadow_nxt;
        end else begin
            scan_out <= 1'b0;
        end
    end
endmodule

module scan_ctrl_unit #(
    parameter int DATA_W = 16,
    parameter int CHAINS = 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     start,
    input  logic                     rotate,
    input  logic                     abort,
    input  logic [CHAINS*DATA_W-1:0] data_in,
    input  logic [CHAINS-1:0]        scan_in,
    output logic [CHAINS-1:0]        scan_out,
    output logic                     scan_enable,
    output logic                     ctrl_feedback,
    output logic                     scan_shift_feedback,
    output logic [CHAINS*DATA_W-1:0] capture_data,
    output logic                     done
);
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic              rot_q;
    logic              load;
    logic              shift;
    logic              last;

    logic [CHAINS-1:0][DATA_W-1:0] data_lane;
    logic [CHAINS-1:0][DATA_W-1:0] cap_lane;

    assign data_lane    = data_in;
    assign capture_data = cap_lane;

    always_comb begin
        state_nxt           = state;
        load                = 1'b0;
        shift               = 1'b0;
        last                = (count == '0);
        scan_enable         = 1'b0;
        scan_shift_feedback = 1'b0;
        ctrl_feedback       = 1'b0;
        done                = 1'b0;
        case (state)
            IDLE: begin
                // abort beats start when both are high
                if (start && !abort) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                scan_enable   = 1'b1;
                ctrl_feedback = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    shift               = 1'b1;
                    scan_shift_feedback = 1'b1;
                    if (last)
                        state_nxt = DONE;
                end
            end
            DONE: begin
                ctrl_feedback = 1'b1;
                done          = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            count <= '0;
            rot_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                count <= CNT_INIT;
                rot_q <= rotate;
            end else if (shift && !last) begin
                count <= count - 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CHAINS; c++) begin : g_lane
        scan_ctrl_lane #(.DATA_W(DATA_W)) u_lane (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .load     (load),
            .shift    (shift),
            .last     (last),
            .rot_mode (rot_q),
            .data     (data_lane[c]),
            .scan_in  (scan_in[c]),
            .scan_out (scan_out[c]),
            .capture  (cap_lane[c])
        );
    end
endmodule
